// File: rtl/joy_pkg.sv
// Shared definitions for the joystick direction/fire conditioner:
// direction bit positions, run-time modes and the per-mode allow masks.
package joy_pkg;

  localparam int DIR_RIGHT = 0;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_UP    = 3;

  localparam int AF_W = 8;

  typedef enum logic [1:0] {
    JM_8WAY = 2'd0,
    JM_4WAY = 2'd1,
    JM_2H   = 2'd2,
    JM_2V   = 2'd3
  } joy_mode_t;

  localparam logic [3:0] ALLOW_MASK [4] = '{4'b1111, 4'b1111, 4'b0011, 4'b1100};

  // Newest-press winner when several directions rise together: up > down > left > right.
  function automatic logic [3:0] prio_onehot(input logic [3:0] r);
    prio_onehot = 4'b0000;
    if (r[DIR_UP])         prio_onehot[DIR_UP]    = 1'b1;
    else if (r[DIR_DOWN])  prio_onehot[DIR_DOWN]  = 1'b1;
    else if (r[DIR_LEFT])  prio_onehot[DIR_LEFT]  = 1'b1;
    else if (r[DIR_RIGHT]) prio_onehot[DIR_RIGHT] = 1'b1;
  endfunction

endpackage

// File: rtl/joy_dir_filter_chan.sv
// One player channel: synchronised direction filter (8-way/4-way/2-way with
// SOCD handling) plus NUM_FIRE autofire slices sharing the tick strobe.
module joy_dir_chan
  import joy_pkg::*;
#(
  parameter int NUM_FIRE     = 2,
  parameter int AF_TICKS     = 4,
  parameter int SOCD_NEUTRAL = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic [1:0]          mode,
  input  logic [NUM_FIRE-1:0] af_en,
  input  logic [3:0]          dir_in,
  input  logic [NUM_FIRE-1:0] fire_in,
  output logic [3:0]          dir_out,
  output logic [NUM_FIRE-1:0] fire_out
);

  localparam logic [AF_W-1:0] AF_LAST = AF_W'(AF_TICKS - 1);

  logic [3:0] s1, s2, mask;
  joy_mode_t  mode_q;
  logic [3:0] allow, v, r, socd, mask_next, dir_next;

  logic [NUM_FIRE-1:0] fs, af_phase;
  logic [AF_W-1:0]     af_cnt [NUM_FIRE];

  always_comb begin
    allow = ALLOW_MASK[mode_q];
    v     = s1 & allow;
    r     = s1 & ~s2 & allow;

    socd = s1;
    if (SOCD_NEUTRAL != 0) begin
      if (s1[DIR_UP] && s1[DIR_DOWN]) begin
        socd[DIR_UP]   = 1'b0;
        socd[DIR_DOWN] = 1'b0;
      end
      if (s1[DIR_LEFT] && s1[DIR_RIGHT]) begin
        socd[DIR_LEFT]  = 1'b0;
        socd[DIR_RIGHT] = 1'b0;
      end
    end

    mask_next = mask;
    dir_next  = 4'b0000;
    if (mode_q == JM_8WAY) begin
      mask_next = 4'b1111;
      dir_next  = socd;
    end else begin
      // A fresh press steals the mask; losing the active direction reopens it.
      if (r != 4'b0000)             mask_next = prio_onehot(r);
      else if ((v & mask) == 4'b0000) mask_next = 4'b1111;
      dir_next = v & mask_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= 4'b0000;
      s2      <= 4'b0000;
      mask    <= 4'b1111;
      mode_q  <= JM_8WAY;
      dir_out <= 4'b0000;
    end else begin
      s1     <= dir_in;
      s2     <= s1;
      mode_q <= joy_mode_t'(mode);
      // Blank one cycle on a mode change so no stale mask leaks across modes.
      if (mode != mode_q) begin
        mask    <= 4'b1111;
        dir_out <= 4'b0000;
      end else begin
        mask    <= mask_next;
        dir_out <= dir_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fs       <= '0;
      af_phase <= '1;
      fire_out <= '0;
      for (int i = 0; i < NUM_FIRE; i++) af_cnt[i] <= '0;
    end else begin
      fs <= fire_in;
      for (int i = 0; i < NUM_FIRE; i++) begin
        fire_out[i] <= fs[i] & (af_en[i] ? af_phase[i] : 1'b1);
        if (!fs[i]) begin
          af_cnt[i]   <= '0;
          af_phase[i] <= 1'b1;
        end else if (tick) begin
          if (af_cnt[i] == AF_LAST) begin
            af_cnt[i]   <= '0;
            af_phase[i] <= ~af_phase[i];
          end else begin
            af_cnt[i] <= af_cnt[i] + AF_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-player joystick conditioner: one joy_dir_chan per player, all outputs
// registered, two-edge latency from input to output.
module joy_dir_filter
  import joy_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_FIRE     = 2,
  parameter int AF_TICKS     = 4,
  parameter int SOCD_NEUTRAL = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            tick,
  input  logic [2*NUM_PLAYERS-1:0]        mode,
  input  logic [NUM_FIRE*NUM_PLAYERS-1:0] af_en,
  input  logic [4*NUM_PLAYERS-1:0]        dir_in,
  input  logic [NUM_FIRE*NUM_PLAYERS-1:0] fire_in,
  output logic [4*NUM_PLAYERS-1:0]        dir_out,
  output logic [NUM_FIRE*NUM_PLAYERS-1:0] fire_out
);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    joy_dir_chan #(
      .NUM_FIRE     (NUM_FIRE),
      .AF_TICKS     (AF_TICKS),
      .SOCD_NEUTRAL (SOCD_NEUTRAL)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (tick),
      .mode     (mode[2*p +: 2]),
      .af_en    (af_en[NUM_FIRE*p +: NUM_FIRE]),
      .dir_in   (dir_in[4*p +: 4]),
      .fire_in  (fire_in[NUM_FIRE*p +: NUM_FIRE]),
      .dir_out  (dir_out[4*p +: 4]),
      .fire_out (fire_out[NUM_FIRE*p +: NUM_FIRE])
    );
  end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Directed bench for joy_dir_filter (2 players, 2 fire buttons, AF_TICKS=4,
// SOCD neutral); expected outputs are queued at stimulus time, popped at sample time.
module tb_joy_dir_filter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic [3:0] mode;
  logic [3:0] af_en;
  logic [7:0] dir_in;
  logic [3:0] fire_in;
  logic [7:0] dir_out;
  logic [3:0] fire_out;

  typedef struct {
    logic [7:0] d;
    logic [3:0] f;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  joy_dir_filter #(
    .NUM_PLAYERS(2), .NUM_FIRE(2), .AF_TICKS(4), .SOCD_NEUTRAL(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .mode(mode), .af_en(af_en),
    .dir_in(dir_in), .fire_in(fire_in), .dir_out(dir_out), .fire_out(fire_out)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] f, input string tag);
    exp_t e;
    e.d = d; e.f = f; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL sb_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    assert ({dir_out, fire_out} === {e.d, e.f}) else begin
      n_bad++;
      $display("FAIL %s: got dir=%b fire=%b, want dir=%b fire=%b",
               e.tag, dir_out, fire_out, e.d, e.f);
      $error("check %s", e.tag);
    end
  endtask

  initial begin
    reset_n = 1'b0; tick = 1'b0; mode = 4'b0000; af_en = 4'b0000;
    dir_in = 8'hFF; fire_in = 4'hF;
    cyc(3);
    push(8'h00, 4'h0, "rst_hold"); check();

    reset_n = 1'b1;
    push(8'h00, 4'h0, "rel_lat1"); cyc(1); check();
    push(8'h00, 4'hF, "rel_lat2"); cyc(1); check();

    dir_in = 8'h0E; fire_in = 4'h0;
    push(8'h02, 4'h0, "socd_ud"); cyc(2); check();
    dir_in = 8'hC9;
    push(8'h09, 4'h0, "socd_pass"); cyc(2); check();

    mode = 4'b0001;
    push(8'h00, 4'h0, "msw_blank"); cyc(1); check();
    push(8'h09, 4'h0, "msw_pass"); cyc(1); check();
    dir_in = 8'hCD;
    push(8'h04, 4'h0, "msw_down"); cyc(2); check();

    dir_in = 8'hC0;
    push(8'h00, 4'h0, "4w_rel"); cyc(2); check();
    dir_in = 8'hC1;
    push(8'h01, 4'h0, "4w_right"); cyc(2); check();
    dir_in = 8'hC9;
    push(8'h08, 4'h0, "4w_up"); cyc(2); check();
    dir_in = 8'hC1;
    push(8'h01, 4'h0, "4w_relup"); cyc(2); check();

    mode = 4'b0010; dir_in = 8'hCA;
    push(8'h02, 4'h0, "2h_ul"); cyc(2); check();
    dir_in = 8'hC8;
    push(8'h00, 4'h0, "2h_u"); cyc(2); check();

    mode = 4'b0011; dir_in = 8'hC6;
    push(8'h04, 4'h0, "2v_dl"); cyc(2); check();
    dir_in = 8'hCF;
    push(8'h08, 4'h0, "2v_prio"); cyc(2); check();
    dir_in = 8'h7F;
    push(8'h48, 4'h0, "p1_lr"); cyc(2); check();

    af_en = 4'b0001;
    repeat (3) begin
      tick = 1'b1; cyc(1); tick = 1'b0; cyc(2);
    end
    push(8'h48, 4'h0, "af_idle"); check();

    fire_in = 4'b0011;
    push(8'h48, 4'b0011, "af_press"); cyc(2); check();

    // Button 0 high for ticks 1..3 after press, low after 4th..7th, high after 8th..11th, low after 12th.
    for (int n = 1; n <= 12; n++) begin
      cyc(7);
      tick = 1'b1; cyc(1); tick = 1'b0;
      push(8'h48, {3'b001, ((n / 4) % 2 == 0)}, $sformatf("af_tick%0d", n));
      cyc(2); check();
    end

    af_en = 4'b0000;
    push(8'h48, 4'b0011, "af_dis"); cyc(1); check();
    fire_in = 4'b0000;
    push(8'h48, 4'b0000, "af_rel"); cyc(2); check();
    af_en = 4'b0001; fire_in = 4'b0011;
    push(8'h48, 4'b0011, "af_repress"); cyc(2); check();

    #2 reset_n = 1'b0;
    #1 push(8'h00, 4'h0, "arst"); check();
    cyc(1);
    reset_n = 1'b1;
    push(8'h00, 4'h0, "arst_lat1"); cyc(1); check();
    push(8'h48, 4'b0011, "arst_rel"); cyc(1); check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
